// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue path: width helpers, alu_op bit
// positions and the instruction-class decode used by the issue controller.
package vec_pkg;

  // Bits needed to index n items (at least 1).
  function automatic int bitwidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((n >> (r + 1)) != 0) r = r + 1;
    return r;
  endfunction

  localparam int ALU_OP_W = 21;

  localparam int OP_VADD    = 0;
  localparam int OP_VSUB    = 1;
  localparam int OP_VMUL    = 2;
  localparam int OP_VDIV    = 3;
  localparam int OP_VREM    = 4;
  localparam int OP_VAND    = 5;
  localparam int OP_VOR     = 6;
  localparam int OP_VXOR    = 7;
  localparam int OP_VSLL    = 8;
  localparam int OP_VSRL    = 9;
  localparam int OP_VSRA    = 10;
  localparam int OP_VMIN    = 11;
  localparam int OP_VMAX    = 12;
  localparam int OP_VMERGE  = 13;
  localparam int OP_VMV     = 14;
  localparam int OP_VREDSUM = 15;
  localparam int OP_VMSEQ   = 16;
  localparam int OP_VMSNE   = 17;
  localparam int OP_VMSLT   = 18;
  localparam int OP_VMSLE   = 19;
  localparam int OP_VMSGT   = 20;

  function automatic logic is_alu_class(input logic [ALU_OP_W-1:0] alu_op,
                                        input logic vid, input logic vcpop);
    return (|alu_op) | vid | vcpop;
  endfunction

  function automatic logic is_mem_class(input logic load, input logic iload,
                                        input logic store, input logic istore);
    return load | iload | store | istore;
  endfunction

  function automatic logic uses_src1(input logic alu_cls, input logic vid,
                                     input logic store, input logic istore,
                                     input logic esc_scalar);
    return ((alu_cls & ~vid) | store | istore) & ~esc_scalar;
  endfunction

  function automatic logic uses_src2(input logic alu_cls, input logic vid,
                                     input logic vcpop, input logic iload,
                                     input logic istore, input logic esc_scalar);
    return ((alu_cls & ~vid & ~vcpop) | iload | istore) & ~esc_scalar;
  endfunction

  function automatic logic writes_dst(input logic alu_cls, input logic vcpop,
                                      input logic load, input logic iload);
    return (alu_cls & ~vcpop) | load | iload;
  endfunction

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// Queue-head, dispatch and writeback signals between the decoded-instruction
// FIFO, the issue controller and the execution pipes.
interface vec_issue_ctrl_if
  import vec_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 32
);
  localparam int RW = bitwidth(NUM_REGS);
  localparam int VW = bitwidth(MVL) + 1;

  logic                  empty;
  logic                  setvl, load, iload, store, istore, vid, vcpop, masked_op;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [1:0]            esc;
  logic [RW-1:0]         src1, src2, dst;
  logic [DATA_WIDTH-1:0] setvl_val;
  logic                  stalling;
  logic                  alu_issue, alu_ready, alu_idle;
  logic                  mem_issue, mem_done;
  logic                  wb_alu_valid, wb_mem_valid;
  logic [RW-1:0]         wb_alu_reg, wb_mem_reg;
  logic [VW-1:0]         vl;
  logic [31:0]           stall_cycles;

  modport slave (
    input  empty, setvl, load, iload, store, istore, vid, vcpop, masked_op,
           alu_op, esc, src1, src2, dst, setvl_val,
           alu_ready, alu_idle, mem_done,
           wb_alu_valid, wb_alu_reg, wb_mem_valid, wb_mem_reg,
    output stalling, alu_issue, mem_issue, vl, stall_cycles
  );

  modport master (
    output empty, setvl, load, iload, store, istore, vid, vcpop, masked_op,
           alu_op, esc, src1, src2, dst, setvl_val,
           alu_ready, alu_idle, mem_done,
           wb_alu_valid, wb_alu_reg, wb_mem_valid, wb_mem_reg,
    input  stalling, alu_issue, mem_issue, vl, stall_cycles
  );

endinterface

// File: rtl/vec_scoreboard.sv
// Per-register busy bits: one set port for issue, two clear ports for the
// ALU and load writebacks, combinational lookups for the issue checks.
module vec_scoreboard
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RW       = bitwidth(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr0_en,
  input  logic [RW-1:0] clr0_idx,
  input  logic          clr1_en,
  input  logic [RW-1:0] clr1_idx,
  input  logic [RW-1:0] rd_src1,
  input  logic [RW-1:0] rd_src2,
  input  logic [RW-1:0] rd_dst,
  output logic          busy_src1,
  output logic          busy_src2,
  output logic          busy_dst,
  output logic          busy_v0,
  output logic          any_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr0_en) busy_d[clr0_idx] = 1'b0;
    if (clr1_en) busy_d[clr1_idx] = 1'b0;
    // NOTE: blocking assignments in order: the set comes last so it overrides a same-cycle clear.
    if (set_en)  busy_d[set_idx]  = 1'b1;
  end

  // NOTE: the busy bits must reset so instructions lost to a reset cannot block new ones.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_src1 = busy_q[rd_src1];
  assign busy_src2 = busy_q[rd_src2];
  assign busy_dst  = busy_q[rd_dst];
  assign busy_v0   = busy_q[0];
  assign any_busy  = |busy_q;

endmodule

// File: rtl/vec_issue_ctrl.sv
// Issue stage of the vector unit: checks the FIFO head against the register
// scoreboard and pipe availability, then either dispatches or stalls it.
module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 32
) (
  input logic             clk,
  input logic             rst,
  vec_issue_ctrl_if.slave io
);

  localparam int RW = bitwidth(NUM_REGS);
  localparam int VW = bitwidth(MVL) + 1;

  logic alu_cls, mem_cls, rd_src1, rd_src2, wr_dst;
  logic busy_src1, busy_src2, busy_dst, busy_v0, any_busy;
  logic block, head_go, issue, setvl_issue;

  logic                  mem_busy_q, mem_busy_d;
  logic [VW-1:0]         vl_q, vl_d;
  logic [31:0]           stall_cycles_q, stall_cycles_d;

  always_comb begin
    alu_cls = is_alu_class(io.alu_op, io.vid, io.vcpop);
    mem_cls = is_mem_class(io.load, io.iload, io.store, io.istore);
    rd_src1 = uses_src1(alu_cls, io.vid, io.store, io.istore, io.esc[0]);
    rd_src2 = uses_src2(alu_cls, io.vid, io.vcpop, io.iload, io.istore, io.esc[1]);
    wr_dst  = writes_dst(alu_cls, io.vcpop, io.load, io.iload);

    block = (rd_src1 & busy_src1)
          | (rd_src2 & busy_src2)
          | (io.masked_op & busy_v0)
          | (wr_dst & busy_dst)
          | (alu_cls & ~io.alu_ready)
          | (mem_cls & mem_busy_q)
          | (io.setvl & (any_busy | mem_busy_q | ~io.alu_idle));

    // Decisions are combinational, so reset must mask them explicitly.
    head_go     = ~rst & ~io.empty;
    issue       = head_go & ~block;
    setvl_issue = issue & io.setvl;
  end

  assign io.stalling  = head_go & block;
  assign io.alu_issue = issue & alu_cls;
  assign io.mem_issue = issue & mem_cls;

  vec_scoreboard #(.NUM_REGS(NUM_REGS), .RW(RW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue & wr_dst),
    .set_idx   (io.dst),
    .clr0_en   (io.wb_alu_valid),
    .clr0_idx  (io.wb_alu_reg),
    .clr1_en   (io.wb_mem_valid),
    .clr1_idx  (io.wb_mem_reg),
    .rd_src1   (io.src1),
    .rd_src2   (io.src2),
    .rd_dst    (io.dst),
    .busy_src1 (busy_src1),
    .busy_src2 (busy_src2),
    .busy_dst  (busy_dst),
    .busy_v0   (busy_v0),
    .any_busy  (any_busy)
  );

  always_comb begin
    mem_busy_d     = mem_busy_q;
    vl_d           = vl_q;
    stall_cycles_d = stall_cycles_q;

    if (io.mem_done)  mem_busy_d = 1'b0;
    if (io.mem_issue) mem_busy_d = 1'b1;

    // Compare at full scalar width so large requests saturate instead of wrapping.
    if (setvl_issue) begin
      if (io.setvl_val > DATA_WIDTH'(MVL)) vl_d = VW'(MVL);
      else                                 vl_d = io.setvl_val[VW-1:0];
    end

    if (io.stalling && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_busy_q     <= 1'b0;
      vl_q           <= VW'(MVL);
      stall_cycles_q <= '0;
    end else begin
      mem_busy_q     <= mem_busy_d;
      vl_q           <= vl_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign io.vl           = vl_q;
  assign io.stall_cycles = stall_cycles_q;

endmodule
